// File: rtl/hashmap_upsert.sv
// Purpose: upsert front-end; turns (key, delta) updates into hashmap lookup + modify (hit) or queued insert (miss).
// Latency: lookup at accept t, modify/push at t+NUM_PIPES, r_valid at t+NUM_PIPES+1, insert from t+NUM_PIPES+1.
// Backpressure: s_ready_o drops on key hazards (in-flight or queued) and when in-flight + queued >= INS_DEPTH.
// Build option: define HASHMAP_UPSERT_SAT_EN to saturate hit sums; otherwise they wrap.
module hashmap_upsert #(
   parameter int NUM_KEY_BITS = 32,
   parameter int NUM_VAL_BITS = 32,
   parameter int NUM_PIPES    = 2,
   parameter int INS_DEPTH    = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   input  logic [NUM_KEY_BITS-1:0] s_key_i,
   input  logic [NUM_VAL_BITS-1:0] s_delta_i,
   output logic                    lookup_o,
   output logic [NUM_KEY_BITS-1:0] key_o,
   output logic                    modify_o,
   output logic                    del_o,
   output logic [NUM_VAL_BITS-1:0] mod_value_o,
   input  logic                    valid_i,
   input  logic [NUM_VAL_BITS-1:0] value_i,
   output logic                    insert_o,
   output logic [NUM_KEY_BITS-1:0] ins_key_o,
   output logic [NUM_VAL_BITS-1:0] ins_value_o,
   input  logic                    busy_i,
   output logic                    r_valid_o,
   output logic [NUM_KEY_BITS-1:0] r_key_o,
   output logic [NUM_VAL_BITS-1:0] r_value_o,
   output logic                    r_new_o
);

   typedef struct packed {
      logic [NUM_KEY_BITS-1:0] key;
      logic [NUM_VAL_BITS-1:0] val;
   } entry_t;

   localparam int LAST = NUM_PIPES - 1;
   localparam int PW   = (INS_DEPTH > 1) ? $clog2(INS_DEPTH) : 1;
   localparam int OW   = $clog2(NUM_PIPES + INS_DEPTH + 1);

   // in-flight pipe: one slot per hashmap lookup stage
   logic [NUM_PIPES-1:0] pvld_q, pvld_d;
   entry_t               pent_q [NUM_PIPES];
   entry_t               pent_d [NUM_PIPES];

   // pending-insert FIFO with a per-slot occupied bit so hazards can scan it
   entry_t               mem_q [INS_DEPTH];
   entry_t               mem_d [INS_DEPTH];
   logic [INS_DEPTH-1:0] occ_q, occ_d;
   logic [PW-1:0]        rd_q, rd_d, wr_q, wr_d;

   // retire register
   logic                 r_valid_q, r_valid_d;
   logic                 r_new_q, r_new_d;
   entry_t               r_ent_q, r_ent_d;

   logic                 hazard, acc, res_vld, hit, push, pop;
   logic [OW-1:0]        occ_cnt;
   logic [NUM_VAL_BITS-1:0] sum;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(INS_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // accept decision: key hazards against pipe and FIFO (popping head included), plus occupancy cap
   always_comb begin
      hazard  = 1'b0;
      occ_cnt = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         if (pvld_q[i] && (pent_q[i].key == s_key_i)) hazard = 1'b1;
         occ_cnt = occ_cnt + OW'(pvld_q[i]);
      end
      for (int j = 0; j < INS_DEPTH; j++) begin
         if (occ_q[j] && (mem_q[j].key == s_key_i)) hazard = 1'b1;
         occ_cnt = occ_cnt + OW'(occ_q[j]);
      end
      s_ready_o = !rst_i && !hazard && (occ_cnt < OW'(INS_DEPTH));
      acc       = s_valid_i && s_ready_o;
   end

   // resolve the last stage against the hashmap result, drain the FIFO head
   always_comb begin
      res_vld = pvld_q[LAST] && !rst_i;
      hit     = res_vld && valid_i;
      push    = res_vld && !valid_i;
      pop     = (occ_q != '0) && !busy_i && !rst_i;
`ifdef HASHMAP_UPSERT_SAT_EN
      begin
         logic [NUM_VAL_BITS:0] sum_full;
         sum_full = {1'b0, value_i} + {1'b0, pent_q[LAST].val};
         sum      = sum_full[NUM_VAL_BITS] ? '1 : sum_full[NUM_VAL_BITS-1:0];
      end
`else
      sum = value_i + pent_q[LAST].val;
`endif
      lookup_o    = acc;
      key_o       = rst_i ? '0 : s_key_i;
      modify_o    = hit;
      del_o       = 1'b0;
      mod_value_o = hit ? sum : '0;
      insert_o    = pop;
      ins_key_o   = pop ? mem_q[rd_q].key : '0;
      ins_value_o = pop ? mem_q[rd_q].val : '0;
      r_valid_o   = r_valid_q && !rst_i;
      r_new_o     = r_new_q && !rst_i;
      r_key_o     = rst_i ? '0 : r_ent_q.key;
      r_value_o   = rst_i ? '0 : r_ent_q.val;
   end

   // next state: shift pipe, FIFO push/pop, build retire record
   always_comb begin
      pvld_d[0] = acc;
      pent_d[0] = '{key: s_key_i, val: s_delta_i};
      for (int i = 1; i < NUM_PIPES; i++) begin
         pvld_d[i] = pvld_q[i-1];
         pent_d[i] = pent_q[i-1];
      end
      mem_d = mem_q;
      occ_d = occ_q;
      rd_d  = rd_q;
      wr_d  = wr_q;
      // a push into an empty FIFO is not visible to pop until next cycle
      if (pop) begin
         occ_d[rd_q] = 1'b0;
         rd_d        = ptr_inc(rd_q);
      end
      if (push) begin
         mem_d[wr_q] = pent_q[LAST];
         occ_d[wr_q] = 1'b1;
         wr_d        = ptr_inc(wr_q);
      end
      r_valid_d = res_vld;
      r_new_d   = push;
      r_ent_d   = '0;
      if (res_vld) begin
         r_ent_d.key = pent_q[LAST].key;
         r_ent_d.val = hit ? sum : pent_q[LAST].val;
      end
   end

   // control state with synchronous reset; reset discards in-flight and queued work
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pvld_q    <= '0;
         occ_q     <= '0;
         rd_q      <= '0;
         wr_q      <= '0;
         r_valid_q <= 1'b0;
         r_new_q   <= 1'b0;
         r_ent_q   <= '0;
      end else begin
         pvld_q    <= pvld_d;
         occ_q     <= occ_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         r_valid_q <= r_valid_d;
         r_new_q   <= r_new_d;
         r_ent_q   <= r_ent_d;
      end
   end

   // payload storage; qualified by pvld_q / occ_q so it needs no reset
   always_ff @(posedge clk_i) begin
      pent_q <= pent_d;
      mem_q  <= mem_d;
   end

endmodule

// File: tb/tb_hashmap_upsert.sv
// Testbench for hashmap_upsert: directed updates against a behavioural hashmap,
// expected retire/modify/insert records queued at acceptance and checked by a monitor.
module tb_hashmap_upsert;
   localparam int NP = 2;
   localparam int ID = 4;
`ifdef HASHMAP_UPSERT_SAT_EN
   localparam logic [31:0] OVF_EXP = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] OVF_EXP = 32'h0000_0010;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid, s_ready;
   logic [31:0] s_key, s_delta;
   logic        lookup, modify, del, insert, busy, valid_r;
   logic [31:0] key, mod_value, value_r, ins_key, ins_value;
   logic        r_valid, r_new;
   logic [31:0] r_key, r_value;

   always #5 clk = ~clk;

   hashmap_upsert #(.NUM_KEY_BITS(32), .NUM_VAL_BITS(32), .NUM_PIPES(NP), .INS_DEPTH(ID)) dut (
      .clk_i(clk), .rst_i(rst),
      .s_valid_i(s_valid), .s_ready_o(s_ready), .s_key_i(s_key), .s_delta_i(s_delta),
      .lookup_o(lookup), .key_o(key),
      .modify_o(modify), .del_o(del), .mod_value_o(mod_value),
      .valid_i(valid_r), .value_i(value_r),
      .insert_o(insert), .ins_key_o(ins_key), .ins_value_o(ins_value),
      .busy_i(busy),
      .r_valid_o(r_valid), .r_key_o(r_key), .r_value_o(r_value), .r_new_o(r_new)
   );

   typedef struct { logic [31:0] key; logic [31:0] val; bit isnew; int cyc; } ret_t;
   typedef struct { logic [31:0] key; logic [31:0] val; int cyc; bit exact; } ins_t;
   typedef struct { logic [31:0] val; int cyc; } mod_t;

   ret_t ret_q[$];
   ins_t ins_q[$];
   mod_t mod_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [31:0] hm [logic [31:0]];
   bit          rsp_v   [int];
   logic [31:0] rsp_val [int];
   logic [31:0] rsp_key [int];
   int          ins_cyc [logic [31:0]];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // cycle counter and hashmap lookup response, presented NP cycles after the lookup
   initial begin
      valid_r = 1'b0;
      value_r = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         valid_r = rsp_v.exists(cyc) ? rsp_v[cyc] : 1'b0;
         value_r = rsp_val.exists(cyc) ? rsp_val[cyc] : 32'h0;
      end
   end

   // monitor: hashmap model updates plus scoreboard pops
   initial begin
      ret_t re;
      ins_t ie;
      mod_t me;
      forever begin
         @(negedge clk);
         if (insert) begin
            hm[ins_key]      = ins_value;
            ins_cyc[ins_key] = cyc;
            if (ins_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_insert: got key 0x%0h at cycle %0d, expected no insert", ins_key, cyc);
            end else begin
               ie = ins_q.pop_front();
               chk("ins_key", ins_key, ie.key);
               chk("ins_value", ins_value, ie.val);
               if (ie.exact) chk("ins_cycle", cyc, ie.cyc);
               else begin
                  n_tests++;
                  if (cyc < ie.cyc) begin
                     n_fail++;
                     $display("FAIL ins_cycle_min: got cycle %0d, expected >= %0d", cyc, ie.cyc);
                  end
               end
            end
         end
         if (modify) begin
            if (rsp_key.exists(cyc)) hm[rsp_key[cyc]] = mod_value;
            if (mod_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_modify: got mod_value 0x%0h at cycle %0d, expected no modify", mod_value, cyc);
            end else begin
               me = mod_q.pop_front();
               chk("mod_value", mod_value, me.val);
               chk("mod_cycle", cyc, me.cyc);
               chk("mod_del", del, 1'b0);
            end
         end
         if (lookup) begin
            rsp_key[cyc+NP] = key;
            rsp_v[cyc+NP]   = hm.exists(key);
            rsp_val[cyc+NP] = hm.exists(key) ? hm[key] : 32'h0;
         end
         if (r_valid) begin
            if (ret_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_retire: got key 0x%0h at cycle %0d, expected no r_valid", r_key, cyc);
            end else begin
               re = ret_q.pop_front();
               chk("r_key", r_key, re.key);
               chk("r_value", r_value, re.val);
               chk("r_new", r_new, re.isnew);
               chk("r_cycle", cyc, re.cyc);
            end
         end
      end
   end

   // enters and leaves at posedge+1; acc returns the acceptance cycle
   task automatic send(input logic [31:0] k, input logic [31:0] d, input logic [31:0] ev,
                       input bit isnew, input bit track, output int acc);
      int n;
      bit got;
      s_valid = 1'b1; s_key = k; s_delta = d;
      n = 0; got = 1'b0; acc = -1;
      while (!got && n < 200) begin
         @(negedge clk);
         if (s_ready) got = 1'b1;
         else n++;
      end
      if (!got) begin
         n_tests++; n_fail++;
         $display("FAIL accept_timeout: key 0x%0h got no acceptance in 200 cycles, expected acceptance", k);
      end else begin
         acc = cyc;
         chk("lookup", lookup, 1'b1);
         chk("lookup_key", key, k);
         if (track) begin
            ret_q.push_back('{key: k, val: ev, isnew: isnew, cyc: cyc + NP + 1});
            if (isnew) ins_q.push_back('{key: k, val: d, cyc: cyc + NP + 1, exact: !busy});
            else       mod_q.push_back('{val: ev, cyc: cyc + NP});
         end
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ctrl"}, {s_ready, lookup, modify, del, insert, r_valid, r_new}, 7'b0);
      chk({tag, "_key"}, key, 32'h0);
      chk({tag, "_mod_value"}, mod_value, 32'h0);
      chk({tag, "_ins_data"}, {ins_key, ins_value}, 64'h0);
      chk({tag, "_r_data"}, {r_key, r_value}, 64'h0);
   endtask

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a, a1, a2, a5, bfall;
      rst = 1'b1; busy = 1'b0;
      s_valid = 1'b1; s_key = 32'hDEAD_BEEF; s_delta = 32'h1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0; s_valid = 1'b0;
      idle(2);

      // miss on empty map, then hit on the same key: 5, then 5+3=8
      send(32'h10, 32'd5, 32'd5, 1'b1, 1'b1, a);
      idle(4);
      send(32'h10, 32'd3, 32'd8, 1'b0, 1'b1, a);
      idle(4);

      // same key back to back: second waits until the first has popped (t+3), accepted t+4, hits 5+5
      send(32'h20, 32'd5, 32'd5, 1'b1, 1'b1, a1);
      send(32'h20, 32'd5, 32'd10, 1'b0, 1'b1, a2);
      chk("same_key_stall", a2 - a1, 4);
      idle(6);

      // busy held 10 cycles: four misses fill occupancy, fifth waits, inserts drain in order
      busy = 1'b1; bfall = 0;
      fork
         begin
            repeat (10) @(posedge clk);
            #1;
            busy  = 1'b0;
            bfall = cyc;
         end
      join_none
      send(32'd1, 32'd1, 32'd1, 1'b1, 1'b1, a);
      send(32'd2, 32'd2, 32'd2, 1'b1, 1'b1, a);
      send(32'd3, 32'd3, 32'd3, 1'b1, 1'b1, a);
      send(32'd4, 32'd4, 32'd4, 1'b1, 1'b1, a);
      send(32'd5, 32'd5, 32'd5, 1'b1, 1'b1, a5);
      chk("full_release", a5, bfall + 1);
      idle(8);
      chk("drain_1", ins_cyc.exists(32'd1) ? ins_cyc[32'd1] : -1, bfall);
      chk("drain_2", ins_cyc.exists(32'd2) ? ins_cyc[32'd2] : -1, bfall + 1);
      chk("drain_3", ins_cyc.exists(32'd3) ? ins_cyc[32'd3] : -1, bfall + 2);
      chk("drain_4", ins_cyc.exists(32'd4) ? ins_cyc[32'd4] : -1, bfall + 3);

      // overflow: 0xFFFFFFF0 + 0x20
      send(32'h40, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b1, 1'b1, a);
      idle(4);
      send(32'h40, 32'h20, OVF_EXP, 1'b0, 1'b1, a);
      idle(4);

      // reset one cycle after accepting a miss while busy: nothing may follow
      busy = 1'b1;
      send(32'h30, 32'd7, 32'd7, 1'b1, 1'b0, a);
      rst = 1'b1; s_valid = 1'b1; s_key = 32'h55;
      @(negedge clk);
      chk_reset_outputs("midreset");
      @(posedge clk); #1;
      busy = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midreset2");
      @(posedge clk); #1;
      rst = 1'b0; s_valid = 1'b0;
      idle(8);
      send(32'h30, 32'd7, 32'd7, 1'b1, 1'b1, a);
      idle(8);

      chk("ret_q_empty", ret_q.size(), 0);
      chk("ins_q_empty", ins_q.size(), 0);
      chk("mod_q_empty", mod_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hashmap_upsert.md
# hashmap_upsert

Upsert front-end that turns a valid/ready stream of (key, delta) updates into accumulate operations on the hashmap, for example per-flow counters. Each update issues a lookup. NUM_PIPES cycles later it issues a modify on a hit, or queues an insert on a miss. Inserts drain through an internal FIFO whenever the hashmap is not busy. The block sits directly upstream of the hashmap and drives its lookup/modify and insert interfaces.

## Interface
- NUM_KEY_BITS, 32, key width
- NUM_VAL_BITS, 32, value/delta width
- NUM_PIPES, 2, hashmap lookup latency; must equal the hashmap's value, ≥1
- INS_DEPTH, 4, pending-insert FIFO depth; ≥1; full throughput needs ≥ NUM_PIPES+1
- clk  in  1  clock
- rst  in  1  reset; synchronous to clk, active-high
- s_valid / s_ready  in / out  1 / 1  update handshake
- s_key / s_delta  in  NUM_KEY_BITS / NUM_VAL_BITS  update key, increment
- lookup, key  out  1, NUM_KEY_BITS  to hashmap lookup port
- modify, del, mod_value  out  1, 1, NUM_VAL_BITS  to hashmap modify port; del is constant 0
- valid, value  in  1, NUM_VAL_BITS  hashmap lookup result
- insert, ins_key, ins_value  out  1, NUM_KEY_BITS, NUM_VAL_BITS  to hashmap insert port
- busy  in  1  hashmap insert busy
- r_valid, r_key, r_value, r_new  out  1, NUM_KEY_BITS, NUM_VAL_BITS, 1  retired update: new stored value; r_new=1 if inserted

## Operation
- Accept: acc = s_valid && s_ready. In the same cycle, lookup=acc and key=s_key (combinational).
- In-flight pipe: NUM_PIPES stages, each holding {vld, key, delta}, shifted every cycle.
- Hazard stall: s_ready=0 when any of these holds:
  - rst is high;
  - s_key equals the key of any valid in-flight stage;
  - s_key equals the key of any occupied FIFO entry, including one popping this cycle;
  - (in-flight count + FIFO count) ≥ INS_DEPTH.
- s_ready depends on s_key. This is intentional: it guarantees that a key is never inserted twice.
- Resolve at the last stage (vld set):
  - valid=1 (hit): modify=1, mod_value=value+delta, del=0.
  - valid=0 (miss): push {key, delta} into the FIFO. A push can never overflow because of the occupancy rule.
- Drain: insert = FIFO non-empty && !busy; ins_key/ins_value = head; pop on the same cycle.
  - insert and lookup may coincide; the hashmap treats the insert as first.
  - Drain is strictly FIFO order.
- Retire: a registered r_valid pulses one cycle after resolve.
  - Hit: r_value = the modified value, r_new=0.
  - Miss: r_value = delta, r_new=1.
- Arithmetic: NUM_VAL_BITS unsigned. Overflow handling is set by the macro in Configuration.

## Timing
- Reset values: s_ready, lookup, modify, del, insert, r_valid = 0; all data outputs = 0; pipe vld bits and FIFO cleared.
- Acceptance at cycle t gives:
  - lookup at t;
  - modify or FIFO push at t+NUM_PIPES;
  - r_valid at t+NUM_PIPES+1.
- Miss path: insert at t+NUM_PIPES+1 at the earliest (push registered, then pop), or later while busy=1.
- Throughput: one update per cycle for distinct keys. The same key is re-accepted at the earliest at t+NUM_PIPES+1 if hit, later if a miss is still queued.
- FIFO full with busy held high: s_ready stays 0; no loss.
- Simultaneous push and pop: count is unchanged; push into an empty FIFO is not popped the same cycle.
- Reset mid-operation:
  - in-flight updates and queued inserts are discarded;
  - no modify, insert or r_valid is issued for them after reset;
  - hashmap contents are not affected.

## Configuration
- HASHMAP_UPSERT_SAT_EN defined: hit sum saturates at 2^NUM_VAL_BITS−1.
- Undefined: sum wraps modulo 2^NUM_VAL_BITS.
- Miss values are the delta and are unaffected by the macro.

## Test plan
- Empty map, key 0x10 delta 5, NUM_PIPES=2:
  - lookup at t, valid=0 at t+2;
  - insert with ins_key=0x10, ins_value=5 at t+3;
  - r_valid at t+3 with r_value=5, r_new=1.
- Then key 0x10 delta 3: modify at t+2 with mod_value=8; r_value=8, r_new=0; no insert.
- s_valid held with key 0x20 for two cycles, map empty:
  - second update stalled (s_ready=0) until the first is queued and drained;
  - exactly one insert of 0x20 (value 5 if delta 5);
  - second update hits with r_value=10.
- busy forced high for 10 cycles with misses on keys 1, 2, 3, 4 (INS_DEPTH=4):
  - s_ready drops once occupancy reaches 4;
  - after busy falls, inserts appear in order 1, 2, 3, 4 on consecutive cycles.
- Stored 0xFFFFFFF0, delta 0x20: mod_value=0xFFFFFFFF with HASHMAP_UPSERT_SAT_EN, 0x00000010 without.
- rst asserted one cycle after accepting a miss on key 0x30 with busy=1:
  - no insert and no r_valid follow;
  - all outputs are 0 during reset;
  - a later update of 0x30 misses again.
